// File: rtl/turn_ctl.sv
// Turn scheduler for the two-player game core: AIM -> FLIGHT -> SETTLE round
// sequencing, per-turn time limit (enabled by defining TURN_TIMEOUT_EN) and turn hand-over.
module turn_ctl #(
    parameter int unsigned CLK_HZ        = 65_000_000,
    parameter int unsigned TURN_SEC      = 15,
    parameter int unsigned SETTLE_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       local_player,
    input  logic       fire_local,
    input  logic       fire_remote,
    input  logic       proj_done,
    input  logic       game_over,
    output logic       active_player,
    output logic       my_turn,
    output logic       launch,
    output logic       next_turn,
    output logic       timeout,
    output logic [5:0] time_left,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AIM    = 3'd1,
        S_FLIGHT = 3'd2,
        S_SETTLE = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [5:0] TURN_RELOAD = 6'(TURN_SEC);

    state_t              state_q, state_d;
    logic                active_q, active_d;
    logic                my_turn_q, my_turn_d;
    logic                launch_q, launch_d;
    logic                next_turn_q, next_turn_d;
    logic                timeout_q, timeout_d;
    logic [5:0]          time_left_q, time_left_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                fire_acc;

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
`endif

    // Only the side that owns the turn may fire; the other source is ignored.
    assign fire_acc = (active_q == local_player) ? fire_local : fire_remote;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            active_q    <= 1'b0;
            my_turn_q   <= 1'b0;
            launch_q    <= 1'b0;
            next_turn_q <= 1'b0;
            timeout_q   <= 1'b0;
            time_left_q <= 6'd0;
            settle_q    <= '0;
`ifdef TURN_TIMEOUT_EN
            presc_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            my_turn_q   <= my_turn_d;
            launch_q    <= launch_d;
            next_turn_q <= next_turn_d;
            timeout_q   <= timeout_d;
            time_left_q <= time_left_d;
            settle_q    <= settle_d;
`ifdef TURN_TIMEOUT_EN
            presc_q     <= presc_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        launch_d    = 1'b0;
        next_turn_d = 1'b0;
        timeout_d   = 1'b0;
        time_left_d = time_left_q;
        settle_d    = settle_q;
`ifdef TURN_TIMEOUT_EN
        presc_d     = presc_q;
`endif

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d     = S_AIM;
                    active_d    = 1'b0;
                    time_left_d = TURN_RELOAD;
`ifdef TURN_TIMEOUT_EN
                    presc_d     = '0;
`endif
                end
            end

            S_AIM: begin
                if (fire_acc) begin
                    // Fire takes priority over a simultaneous final timer wrap.
                    launch_d = 1'b1;
                    state_d  = S_FLIGHT;
`ifdef TURN_TIMEOUT_EN
                end else if (presc_q == PRESC_MAX) begin
                    presc_d     = '0;
                    time_left_d = time_left_q - 6'd1;
                    if (time_left_q == 6'd1) begin
                        timeout_d = 1'b1;
                        state_d   = S_SETTLE;
                        settle_d  = SETTLE_LOAD;
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
`endif
                end
            end

            S_FLIGHT: begin
                if (proj_done) begin
                    state_d  = S_SETTLE;
                    settle_d = SETTLE_LOAD;
                end
            end

            S_SETTLE: begin
                if (settle_q == '0) begin
                    if (game_over) begin
                        state_d = S_OVER;
                    end else begin
                        state_d     = S_AIM;
                        active_d    = ~active_q;
                        time_left_d = TURN_RELOAD;
                        next_turn_d = 1'b1;
`ifdef TURN_TIMEOUT_EN
                        presc_d     = '0;
`endif
                    end
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifndef TURN_TIMEOUT_EN
        // Without a time limit the display simply shows the full budget while aiming.
        time_left_d = (state_d == S_AIM) ? TURN_RELOAD : 6'd0;
`endif

        my_turn_d = (state_d == S_AIM) && (active_d == local_player);
    end

    assign active_player = active_q;
    assign my_turn       = my_turn_q;
    assign launch        = launch_q;
    assign next_turn     = next_turn_q;
    assign timeout       = timeout_q;
    assign time_left     = time_left_q;
    assign state         = state_q;

endmodule

// File: tb/tb_turn_ctl.sv
// Directed bench for turn_ctl (CLK_HZ=10, TURN_SEC=3, SETTLE_CYCLES=4, local player 0).
module tb_turn_ctl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       local_player;
    logic       fire_local;
    logic       fire_remote;
    logic       proj_done;
    logic       game_over;
    logic       active_player;
    logic       my_turn;
    logic       launch;
    logic       next_turn;
    logic       timeout;
    logic [5:0] time_left;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    turn_ctl #(
        .CLK_HZ        (10),
        .TURN_SEC      (3),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .local_player  (local_player),
        .fire_local    (fire_local),
        .fire_remote   (fire_remote),
        .proj_done     (proj_done),
        .game_over     (game_over),
        .active_player (active_player),
        .my_turn       (my_turn),
        .launch        (launch),
        .next_turn     (next_turn),
        .timeout       (timeout),
        .time_left     (time_left),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit so outputs are sampled off the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        local_player = 1'b0;
        fire_local   = 1'b0;
        fire_remote  = 1'b0;
        proj_done    = 1'b0;
        game_over    = 1'b0;

        tick(3);
        check("rst_state", 32'(state), 0);
        check("rst_active", 32'(active_player), 0);
        check("rst_my_turn", 32'(my_turn), 0);
        check("rst_launch", 32'(launch), 0);
        check("rst_next_turn", 32'(next_turn), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_time_left", 32'(time_left), 0);

        rst_n = 1'b1;
        tick(1);
        check("idle_hold", 32'(state), 0);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        $display("txn start: state=%0d active=%0d my_turn=%0d time_left=%0d", state, active_player, my_turn, time_left);
        check("start_state", 32'(state), 1);
        check("start_active", 32'(active_player), 0);
        check("start_my_turn", 32'(my_turn), 1);
        check("start_time_left", 32'(time_left), 3);

        // Player 0 fires locally; projectile lands 5 cycles after the fire edge.
        fire_local = 1'b1;
        tick(1);
        fire_local = 1'b0;
        $display("txn fire_local p0: launch=%0d state=%0d", launch, state);
        check("p0_launch", 32'(launch), 1);
        check("p0_flight", 32'(state), 2);
        tick(1);
        check("p0_launch_end", 32'(launch), 0);
        tick(3);
        check("p0_flight_wait", 32'(state), 2);
        proj_done = 1'b1;
        tick(1);
        proj_done = 1'b0;
        check("p0_settle", 32'(state), 3);
        tick(3);
        check("p0_settle_last", 32'(state), 3);
        check("p0_settle_no_nt", 32'(next_turn), 0);
        tick(1);
        $display("txn turn change: state=%0d active=%0d next_turn=%0d my_turn=%0d", state, active_player, next_turn, my_turn);
        check("nt1_state", 32'(state), 1);
        check("nt1_pulse", 32'(next_turn), 1);
        check("nt1_active", 32'(active_player), 1);
        check("nt1_my_turn", 32'(my_turn), 0);
        check("nt1_time_left", 32'(time_left), 3);
        tick(1);
        check("nt1_pulse_end", 32'(next_turn), 0);

        // Player 1's turn: local fire ignored, remote fire accepted with proj_done already high.
        fire_local = 1'b1;
        tick(1);
        fire_local = 1'b0;
        $display("txn fire_local p1: launch=%0d state=%0d", launch, state);
        check("p1_local_ignored", 32'(launch), 0);
        check("p1_still_aim", 32'(state), 1);
        fire_remote = 1'b1;
        proj_done   = 1'b1;
        tick(1);
        fire_remote = 1'b0;
        $display("txn fire_remote p1: launch=%0d state=%0d", launch, state);
        check("p1_remote_launch", 32'(launch), 1);
        check("p1_flight", 32'(state), 2);
        start = 1'b1;
        tick(1);
        start     = 1'b0;
        proj_done = 1'b0;
        check("p1_quick_settle", 32'(state), 3);
        tick(3);
        check("p1_settle_last", 32'(state), 3);
        tick(1);
        $display("txn turn change: state=%0d active=%0d next_turn=%0d my_turn=%0d", state, active_player, next_turn, my_turn);
        check("nt2_state", 32'(state), 1);
        check("nt2_active", 32'(active_player), 0);
        check("nt2_pulse", 32'(next_turn), 1);
        check("nt2_my_turn", 32'(my_turn), 1);

        // Player 0 idles; a remote fire on the wrong turn must be ignored.
        fire_remote = 1'b1;
        tick(1);
        fire_remote = 1'b0;
        check("p0_remote_ignored", 32'(launch), 0);
`ifdef TURN_TIMEOUT_EN
        tick(8);
        check("tl_before_wrap1", 32'(time_left), 3);
        tick(1);
        check("tl_wrap1", 32'(time_left), 2);
        tick(9);
        check("tl_before_wrap2", 32'(time_left), 2);
        tick(1);
        check("tl_wrap2", 32'(time_left), 1);
        tick(9);
        check("tl_before_wrap3", 32'(time_left), 1);
        check("to_not_yet", 32'(timeout), 0);
        tick(1);
        $display("txn timeout: time_left=%0d timeout=%0d state=%0d launch=%0d", time_left, timeout, state, launch);
        check("to_time_left", 32'(time_left), 0);
        check("to_pulse", 32'(timeout), 1);
        check("to_state", 32'(state), 3);
        check("to_no_launch", 32'(launch), 0);
        tick(1);
        check("to_pulse_end", 32'(timeout), 0);
        tick(2);
        check("to_settle_last", 32'(state), 3);
        tick(1);
`else
        tick(29);
        $display("txn no-timeout wait: time_left=%0d timeout=%0d state=%0d", time_left, timeout, state);
        check("nto_time_left", 32'(time_left), 3);
        check("nto_no_timeout", 32'(timeout), 0);
        check("nto_still_aim", 32'(state), 1);
        fire_local = 1'b1;
        tick(1);
        fire_local = 1'b0;
        check("nto_launch", 32'(launch), 1);
        proj_done = 1'b1;
        tick(1);
        proj_done = 1'b0;
        check("nto_settle", 32'(state), 3);
        tick(4);
`endif
        $display("txn turn change: state=%0d active=%0d next_turn=%0d time_left=%0d", state, active_player, next_turn, time_left);
        check("nt3_state", 32'(state), 1);
        check("nt3_active", 32'(active_player), 1);
        check("nt3_pulse", 32'(next_turn), 1);
        check("nt3_time_left", 32'(time_left), 3);

        // Game over is evaluated at the end of SETTLE.
        fire_remote = 1'b1;
        tick(1);
        fire_remote = 1'b0;
        check("go_launch", 32'(launch), 1);
        proj_done = 1'b1;
        tick(1);
        proj_done = 1'b0;
        game_over = 1'b1;
        check("go_settle", 32'(state), 3);
        tick(3);
        check("go_settle_last", 32'(state), 3);
        tick(1);
        $display("txn game_over: state=%0d next_turn=%0d active=%0d", state, next_turn, active_player);
        check("go_over", 32'(state), 4);
        check("go_no_nt", 32'(next_turn), 0);
        check("go_my_turn", 32'(my_turn), 0);
        check("go_active_hold", 32'(active_player), 1);
        tick(2);
        check("go_over_hold", 32'(state), 4);
        game_over = 1'b0;
        start     = 1'b1;
        tick(1);
        start = 1'b0;
        $display("txn restart: state=%0d active=%0d my_turn=%0d next_turn=%0d", state, active_player, my_turn, next_turn);
        check("rs_state", 32'(state), 1);
        check("rs_active", 32'(active_player), 0);
        check("rs_my_turn", 32'(my_turn), 1);
        check("rs_no_nt", 32'(next_turn), 0);
        check("rs_time_left", 32'(time_left), 3);

        // Asynchronous reset in FLIGHT while launch is high.
        fire_local = 1'b1;
        tick(1);
        fire_local = 1'b0;
        check("ar_launch", 32'(launch), 1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn async reset: state=%0d launch=%0d active=%0d time_left=%0d", state, launch, active_player, time_left);
        check("ar_state", 32'(state), 0);
        check("ar_launch_clr", 32'(launch), 0);
        check("ar_my_turn", 32'(my_turn), 0);
        check("ar_time_left", 32'(time_left), 0);
        tick(2);
        check("ar_hold", 32'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
